// File: rtl/sprite_blitter_if.sv
// rtl/sprite_blitter_if.sv - Queue, sprite-storage and framebuffer bus bundle for sprite_blitter
//
// Purpose: groups the three buses the blitter talks on.
//   queue   : is_empty, sprite_id, sprite_x, sprite_y, sprite_scale (head of queue), dequeue (pop)
//   storage : sprite_r0_select, sprite_r0_addr (read request), sprite_r0_data (1-cycle latency)
//   fb      : fb_w_en, fb_w_addr, fb_w_data (write), fb_w_ready (accept)
// master = blitter side, slave = queue/storage/framebuffer side.
interface sprite_blitter_if #(
    parameter int SPRITE_NUM       = 16,
    parameter int SPRITE_ADDR_SIZE = 10,
    parameter int FB_ADDR_W        = 17
);
    localparam int SEL_W = $clog2(SPRITE_NUM);

    logic                    is_empty;
    logic [7:0]              sprite_id;
    logic [15:0]             sprite_x;
    logic [15:0]             sprite_y;
    logic [7:0]              sprite_scale;
    logic                    dequeue;
    logic [SEL_W-1:0]        sprite_r0_select;
    logic [SPRITE_ADDR_SIZE:0] sprite_r0_addr;
    logic [3:0]              sprite_r0_data;
    logic                    fb_w_en;
    logic [FB_ADDR_W-1:0]    fb_w_addr;
    logic [3:0]              fb_w_data;
    logic                    fb_w_ready;

    modport master (
        input  is_empty, sprite_id, sprite_x, sprite_y, sprite_scale,
        output dequeue,
        output sprite_r0_select, sprite_r0_addr,
        input  sprite_r0_data,
        output fb_w_en, fb_w_addr, fb_w_data,
        input  fb_w_ready
    );

    modport slave (
        output is_empty, sprite_id, sprite_x, sprite_y, sprite_scale,
        input  dequeue,
        input  sprite_r0_select, sprite_r0_addr,
        output sprite_r0_data,
        input  fb_w_en, fb_w_addr, fb_w_data,
        output fb_w_ready
    );
endinterface

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - Pops sprite draw commands and blits clipped, scaled, keyed pixels to the framebuffer
//
// Purpose: for each queued command (id, x, y, scale) walk the 2^s-scaled sprite area,
// read source pixels through one storage port and write visible non-zero pixels.
// Ports:
//   clock, reset : posedge clock, synchronous active-high reset
//   enable       : allows popping a new command (an in-flight sprite always completes)
//   busy         : high while a sprite is being processed or a pixel is in flight
//   bus          : queue / storage read / framebuffer write bundle (master side)
module sprite_blitter #(
    parameter int SPRITE_NUM       = 16,
    parameter int SPRITE_ADDR_SIZE = 10,
    parameter int SPRITE_W         = 32,
    parameter int SPRITE_H         = 32,
    parameter int SCREEN_W         = 320,
    parameter int SCREEN_H         = 240,
    parameter int FB_ADDR_W        = 17
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic             busy,
    sprite_blitter_if.master bus
);
    localparam int SEL_W = $clog2(SPRITE_NUM);
    localparam int AW    = SPRITE_ADDR_SIZE + 1;
    localparam int DXW   = $clog2(SPRITE_W) + 3;
    localparam int DYW   = $clog2(SPRITE_H) + 3;
    localparam int PW    = 17;

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DRAIN} state_t;
    state_t state, state_next;

    logic [SEL_W-1:0]     id;
    logic [15:0]          x, y;
    logic [1:0]           s;
    logic [DXW-1:0]       dx, dx_last;
    logic [DYW-1:0]       dy, dy_last;
    logic [PW-1:0]        px, py;
    logic                 visible;
    logic [FB_ADDR_W-1:0] fb_addr;

    // Stage B: one coordinate whose storage data is arriving this cycle.
    logic                 b_valid, b_visible;
    logic [FB_ADDR_W-1:0] b_addr;
    // While stalled the read port already looks at the next coordinate, so
    // the stalled pixel is captured here and replayed until accepted.
    logic                 b_held;
    logic [3:0]           b_data;
    logic [3:0]           pix;
    logic                 stall, advance;

    logic unused_bits;
    assign unused_bits = ^{bus.sprite_id[7:SEL_W], bus.sprite_scale[7:2]};

    always_comb begin
        dx_last = DXW'((SPRITE_W << s) - 1);
        dy_last = DYW'((SPRITE_H << s) - 1);
        px      = PW'(x) + PW'(dx);
        py      = PW'(y) + PW'(dy);
        visible = (px < PW'(SCREEN_W)) && (py < PW'(SCREEN_H));
        fb_addr = FB_ADDR_W'(32'(py) * 32'(SCREEN_W) + 32'(px));
    end

    assign bus.sprite_r0_select = id;
    assign bus.sprite_r0_addr   = AW'(32'(dy >> s) * 32'(SPRITE_W) + 32'(dx >> s));

    assign pix           = b_held ? b_data : bus.sprite_r0_data;
    assign bus.fb_w_en   = b_valid && b_visible && (pix != 4'd0);
    assign bus.fb_w_data = bus.fb_w_en ? pix : 4'd0;
    assign bus.fb_w_addr = b_addr;
    assign stall         = bus.fb_w_en && !bus.fb_w_ready;
    assign advance       = !stall;
    assign busy          = (state != IDLE) || b_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        bus.dequeue = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !bus.is_empty) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                bus.dequeue = 1'b1;
                state_next  = DRAW;
            end
            DRAW: begin
                if (advance && (dx == dx_last) && (dy == dy_last)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (advance) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            id        <= '0;
            x         <= '0;
            y         <= '0;
            s         <= '0;
            dx        <= '0;
            dy        <= '0;
            b_valid   <= 1'b0;
            b_visible <= 1'b0;
            b_addr    <= '0;
            b_held    <= 1'b0;
            b_data    <= '0;
        end else begin
            if (stall) begin
                b_held <= 1'b1;
                b_data <= pix;
            end else begin
                b_held <= 1'b0;
            end
            case (state)
                LOAD: begin
                    id <= bus.sprite_id[SEL_W-1:0];
                    x  <= bus.sprite_x;
                    y  <= bus.sprite_y;
                    s  <= bus.sprite_scale[1:0];
                    dx <= '0;
                    dy <= '0;
                end
                DRAW: begin
                    if (advance) begin
                        b_valid   <= 1'b1;
                        b_visible <= visible;
                        b_addr    <= fb_addr;
                        // The final coordinate is held so the read address stays
                        // valid for stage B through DRAIN.
                        if (dx != dx_last) begin
                            dx <= dx + 1'b1;
                        end else if (dy != dy_last) begin
                            dx <= '0;
                            dy <= dy + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (advance) begin
                        b_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Downstream consumer of the SPI sprite driver.
- Pops draw commands (id, x, y, scale) from the sprite write queue and reads 4-bit sprite pixels through one sprite-storage read port (r0).
- Writes the visible, non-transparent pixels into the framebuffer write port, clipping to the screen and applying power-of-two scaling.
- Runs entirely in the FPGA clock domain.

Parameters:
- SPRITE_NUM, 16, number of sprite slots in storage; select width is $clog2(SPRITE_NUM).
- SPRITE_ADDR_SIZE, 10, storage address MSB index; address width is SPRITE_ADDR_SIZE+1.
- SPRITE_W, 32, sprite width in source pixels.
- SPRITE_H, 32, sprite height in source pixels.
- SCREEN_W, 320, framebuffer width in pixels.
- SCREEN_H, 240, framebuffer height in pixels.
- FB_ADDR_W, 17, framebuffer address width.

Ports:
- clock  in  1  FPGA clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when low, no new command is popped; a sprite already in progress completes.
- is_empty  in  1  queue empty flag.
- sprite_id  in  8  head-of-queue sprite id.
- sprite_x  in  16  head x position, unsigned.
- sprite_y  in  16  head y position, unsigned.
- sprite_scale  in  8  head scale; only bits [1:0] are used.
- dequeue  out  1  single-cycle pulse that pops the queue head.
- sprite_r0_select  out  $clog2(SPRITE_NUM)  storage slot select.
- sprite_r0_addr  out  SPRITE_ADDR_SIZE+1  storage read address.
- sprite_r0_data  in  4  storage read data; valid exactly 1 cycle after the address.
- fb_w_en  out  1  framebuffer write strobe.
- fb_w_addr  out  FB_ADDR_W  framebuffer address, py*SCREEN_W+px.
- fb_w_data  out  4  pixel colour.
- fb_w_ready  in  1  framebuffer accepts the write this cycle.
- busy  out  1  high whenever state != IDLE or the pipeline holds a pixel.

Behaviour:
- Reset: state=IDLE; dequeue=0, fb_w_en=0, busy=0; fb_w_addr, fb_w_data, sprite_r0_addr and sprite_r0_select are all 0; pipeline valid bit cleared. Reset mid-sprite abandons the sprite with no further writes, and the popped entry is not restored.
- Latch stages:
  - IDLE: if enable && !is_empty, go to LOAD.
  - LOAD, 1 cycle: assert dequeue; latch id, x, y, s=scale[1:0]; clear dx=0, dy=0; go to DRAW.
  - dequeue is never high in any other state.
- Scaled size: DW=SPRITE_W<<s, DH=SPRITE_H<<s.
- Walk order: DRAW walks dx 0..DW-1 inner and dy 0..DH-1 outer, one coordinate per advancing cycle.
- Source coordinates: col=dx>>s, row=dy>>s.
- Read request:
  - sprite_r0_addr=row*SPRITE_W+col.
  - sprite_r0_select=id[$clog2(SPRITE_NUM)-1:0].
- Destination: px=x+dx, py=y+dy, computed 17 bits wide with no wrap.
- Pipeline: stage A issues the read address; stage B, one cycle later, holds px/py/visible and uses sprite_r0_data.
- Write rule:
  - stage B asserts fb_w_en when valid && visible && sprite_r0_data!=0. Colour 0 is transparent.
  - visible means px<SCREEN_W && py<SCREEN_H.
- Backpressure:
  - While stage B has fb_w_en=1 and fb_w_ready=0, the whole pipeline stalls: dx, dy and sprite_r0_addr hold, and fb_w_en, fb_w_addr and fb_w_data stay stable.
  - Invisible or transparent pixels never stall.
- Loop end: after the last coordinate (dx=DW-1, dy=DH-1) is issued, go to DRAIN. DRAIN returns to IDLE once stage B has completed.
- Back-to-back: after DRAIN→IDLE, the next LOAD may start the following cycle. There is no overlap between sprites.
- Throughput: with fb_w_ready held high, one source coordinate per cycle. A sprite takes 1 (LOAD) + DW*DH + 1 (DRAIN) cycles from LOAD entry to IDLE.
- enable dropping mid-DRAW has no effect until IDLE; then no pop occurs.
- is_empty rising while in LOAD is not a legal event; the upstream queue guarantees that a non-empty head stays valid until dequeue.
- A sprite entirely off-screen (x>=SCREEN_W) still consumes DW*DH cycles and produces zero writes.

Test Plan:
- Reset then queue empty, 100 cycles → dequeue, fb_w_en and busy stay 0; state IDLE.
- Sprite id 3 at x=10,y=20, scale 0, all storage pixels =5, fb_w_ready=1:
  - exactly one dequeue pulse;
  - 1024 writes, the first to addr 20*320+10=6410 with data 5;
  - busy deasserts 1026 cycles after LOAD.
- Checkerboard sprite with colour 0 on odd pixels → exactly 512 writes, none with data 0.
- Sprite at x=300,y=230, scale 0 → writes only px 300..319 and py 230..239 (200 writes); no addr >= 76800.
- Scale 1 sprite at x=0,y=0 → 64x64 area drawn; fb pixels (0,0),(1,0),(0,1),(1,1) all equal source pixel 0; 4096 writes for an opaque sprite.
- fb_w_ready toggled 0/1 every cycle during opaque sprite → every write held stable while stalled, none lost or duplicated (1024 unique addresses). Reset asserted mid-DRAW → fb_w_en=0 the next cycle and IDLE.
